// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM memory subsystem.
//   sram_state_t      : controller FSM encoding (IDLE, LOW, HIGH, DONE)
//   ADDR_BASE_DEFAULT : byte address that maps to SRAM word 0
//   SRAM_DW           : off-chip SRAM data width in bits
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

  localparam int ADDR_BASE_DEFAULT = 1024;
  localparam int SRAM_DW           = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// 4-bit wait-state down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : reload value (number of extra wait cycles)
//   zero       : high when the count has expired
// The counter decrements on its own whenever it is non-zero and not being
// loaded, so it idles at zero between accesses.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage bridge to a 16-bit asynchronous SRAM. Each 32-bit load/store is
// split into a low and a high halfword access, each lasting WAIT_STATES+1
// cycles, followed by a one-cycle DONE state in which ready rises.
//   clk, rst          : clock, asynchronous active-low reset
//   mem_r_en/mem_w_en : load / store request (store wins if both set)
//   address, data     : byte address and store value, held while ready is low
//   mem_result        : registered load data, updated on HIGH->DONE of a read
//   ready             : low while a request is pending and not yet in DONE
//   sram_addr         : halfword address {word index, half select}
//   sram_dq_out/_in   : pad write / read data
//   sram_dq_oe        : pad output enable (writes only, LOW and HIGH phases)
//   sram_we_n         : active-low write strobe (writes only, LOW and HIGH)
//   dbg_state         : current FSM state, for observation
//
// Handshake: a request is accepted when either enable is high in IDLE. The
// requester must hold its enables, address and data stable until it sees
// ready high; ready high in DONE is the single-cycle completion beat, and a
// request still present in the following IDLE cycle starts a new access.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  output logic [31:0]        mem_result,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic [1:0]         dbg_state
);

  sram_state_t state, state_nx;

  logic                 req;
  logic                 cnt_load;
  logic                 cnt_zero;
  logic                 latch_req;
  logic                 capture_low;
  logic                 capture_high;
  logic                 in_phase;

  logic                 is_write_q;
  logic [SRAM_AW-2:0]   idx_q;
  logic [31:0]          data_q;
  logic [15:0]          low_buf;

  // Byte offset into the window; bits above the index wrap silently and the
  // byte-within-word bits are ignored.
  logic [31:0]          byte_off;
  logic [SRAM_AW-2:0]   idx_nx;
  logic                 unused_off_bits;

  assign byte_off        = address - 32'(ADDR_BASE);
  assign idx_nx          = byte_off[SRAM_AW:2];
  assign unused_off_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

  assign req = mem_r_en | mem_w_en;

  sram_wait_counter u_wait (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (4'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_load     = 1'b0;
    latch_req    = 1'b0;
    capture_low  = 1'b0;
    capture_high = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nx  = ST_LOW;
          cnt_load  = 1'b1;
          latch_req = 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt_zero) begin
          state_nx    = ST_HIGH;
          cnt_load    = 1'b1;
          capture_low = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_nx     = ST_DONE;
          capture_high = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Request latches and read buffer. A reset aborts before capture_high can
  // fire, so a partial read never reaches mem_result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_write_q <= 1'b0;
      idx_q      <= '0;
      data_q     <= 32'd0;
      low_buf    <= 16'd0;
      mem_result <= 32'd0;
    end else begin
      if (latch_req) begin
        is_write_q <= mem_w_en;
        idx_q      <= idx_nx;
        data_q     <= data;
      end
      if (capture_low && !is_write_q) begin
        low_buf <= sram_dq_in;
      end
      if (capture_high && !is_write_q) begin
        mem_result <= {sram_dq_in, low_buf};
      end
    end
  end

  // Pad outputs decode directly from the state register, so asserting reset
  // drops the write strobe immediately.
  assign in_phase    = (state == ST_LOW) || (state == ST_HIGH);
  assign sram_addr   = {idx_q, (state == ST_HIGH)};
  assign sram_dq_out = (state == ST_HIGH) ? data_q[31:16] : data_q[15:0];
  assign sram_dq_oe  = is_write_q & in_phase;
  assign sram_we_n   = ~(is_write_q & in_phase);

  assign ready     = ~(req & (state != ST_DONE));
  assign dbg_state = state;

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the pipeline's MEM stage to an off-chip 16-bit asynchronous SRAM, replacing the single-cycle on-chip data memory. Each 32-bit load or store becomes two 16-bit SRAM accesses with programmable wait states. While an access is in flight, `ready` stays low, and the top level freezes every pipeline register on `~ready`.

## Interface
Parameters:
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, default 18: SRAM address width, in 16-bit halfwords.
- `WAIT_STATES`, default 2: extra cycles per halfword access. Legal range is 0..15.

Ports:
- `clk` input, 1: the single clock. All state updates on the rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `mem_r_en` input, 1: load request from the EXE/MEM register.
- `mem_w_en` input, 1: store request from the EXE/MEM register.
- `address` input, 32: byte address (the ALU result).
- `data` input, 32: store value.
- `mem_result` output, 32: load data, registered.
- `ready` output, 1: access complete or no access pending. Low means freeze the pipeline.
- `sram_addr` output, SRAM_AW: halfword address.
- `sram_dq_out` output, 16: write data driven to the pad.
- `sram_dq_in` input, 16: read data from the pad.
- `sram_dq_oe` output, 1: pad output enable.
- `sram_we_n` output, 1: SRAM write strobe, active-low.

## Operation
- Word index is `(address - ADDR_BASE) >> 2`, modulo 2^(SRAM_AW-1). Addresses outside the window wrap silently. No fault is raised.
- The low halfword goes to `sram_addr = {index, 1'b0}` and carries `data[15:0]`.
- The high halfword goes to `sram_addr = {index, 1'b1}` and carries `data[31:16]`.
- If `mem_w_en` and `mem_r_en` are both high, the access is a write. No read is performed and `mem_result` is unchanged.
- The controller has four states:
  - IDLE: a request (either enable high) moves to LOW, loads the wait counter with WAIT_STATES and latches the access type. With no request, stay in IDLE.
  - LOW: drive the low-half address. When the counter reaches 0, capture `sram_dq_in` into the low byte-pair of the read buffer (reads only), reload the counter and move to HIGH. Otherwise decrement.
  - HIGH: same as LOW for the high half. On expiry, go to DONE.
  - DONE: lasts one cycle, then IDLE.
- `ready` is combinational: `~((mem_r_en | mem_w_en) & (state != DONE))`.
- The MEM stage holds its inputs stable while `ready` is low. The controller does not re-sample `address` or `data` after IDLE. It drives from its latched copies.
- Writes:
  - `sram_we_n` is low and `sram_dq_oe` is high for every cycle of LOW and HIGH.
  - `sram_we_n` returns high for at least the DONE cycle.
- Reads:
  - `sram_we_n` and `sram_dq_oe` stay low.
  - `mem_result` updates to `{high_half, low_half}` on the HIGH→DONE edge and holds until the next read completes.

## Timing
- Reset values: state IDLE, counter 0, `mem_result` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` follows its formula.
- Reset mid-access aborts immediately: `sram_we_n` deasserts asynchronously and no partial read data is written to `mem_result`.
- With a request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W+1.
  - HIGH occupies cycles W+2..2W+2.
  - DONE is cycle 2W+3.
  - `ready` is low for 2W+3 cycles (cycles 0..2W+2) and high in the DONE cycle, when the pipeline advances.
- Back-to-back requests: a new request present in the IDLE cycle after DONE starts immediately. There is no lost cycle beyond that IDLE cycle.
- Each halfword read is sampled in the last cycle of its phase. This allows W+1 cycles of SRAM access time.

## Structure
- Shared package `arm_mem_pkg` holds:
  - the state encoding `sram_state_t` (IDLE, LOW, HIGH, DONE);
  - the `ADDR_BASE` default;
  - the `SRAM_DW=16` constant.
- One sub-module, `sram_wait_counter`: 4-bit down-counter with `load`, `load_val` and `zero` outputs.
- The FSM, address translation and read buffer stay in `sram_controller`.
- The ARM top level replaces `data_memory` with this block and ORs `~ready` into the hazard freeze for IF, ID, EXE and MEM registers.

## Test plan
- Reset with `mem_r_en=1` held → `sram_we_n=1`, `sram_dq_oe=0`, `mem_result=0`. After release, the FSM leaves IDLE on the first edge.
- Store `address=1024`, `data=0xDEADBEEF`, W=2:
  - `sram_addr` 0 shows `0xBEEF`, then `sram_addr` 1 shows `0xDEAD`.
  - `sram_we_n` is low for 6 cycles.
  - `ready` is low for exactly 7 cycles.
- Load `address=1028` against a behavioural SRAM model holding `0x1234` at addr 2 and `0xABCD` at addr 3 → `mem_result=0xABCD1234` in the DONE cycle, held afterwards.
- `mem_r_en` and `mem_w_en` both high with `data=0x5555AAAA` → write occurs and `mem_result` is unchanged.
- Wrap-around: `address=1020` → `sram_addr` = {all-ones index, 0}, then {all-ones index, 1}.
- Reset asserted in HIGH cycle 1 of a store → `sram_we_n` high asynchronously. After release, an immediate load completes correctly with W=0 in 3 cycles of `ready` low.
